// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB-Lite encodings and GPIO slave register map.
//   Contents: HTRANS codes, HRESP codes, HSIZE codes, register word offsets,
//   slave FSM state type and a debug snapshot struct for bound checkers.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Register selects, HADDR[3:2]
    localparam logic [1:0] REG_DATA_OUT   = 2'd0;
    localparam logic [1:0] REG_DATA_IN    = 2'd1;
    localparam logic [1:0] REG_IRQ_EN     = 2'd2;
    localparam logic [1:0] REG_IRQ_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    typedef struct packed {
        slv_state_e state;
        logic [2:0] wait_cnt;
        logic       dphase_valid;
    } slv_dbg_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
//   Two-flop synchroniser for asynchronous inputs plus a one-cycle rising-edge
//   pulse computed from the synchronised value against its previous sample.
//   Ports:
//     clk      in  clock
//     rst_n    in  asynchronous active-low reset
//     async_in in  W asynchronous inputs
//     sync_out out W synchronised inputs
//     rise     out W one-cycle pulse per synchronised 0->1 transition
module gpio_sync_edge #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;

endmodule

// File: rtl/ahb_gpio_slave.sv
// ahb_gpio_slave
//   AHB-Lite GPIO slave: LED output register, synchronised input register,
//   rising-edge interrupt status (write-1-to-clear) with enable mask.
//   Register map (HADDR[3:2]): 0 DATA_OUT RW, 1 DATA_IN RO, 2 IRQ_EN RW,
//   3 IRQ_STATUS W1C. Any HADDR[31:4] != 0 gets a two-cycle ERROR response.
//   Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADYIN at a
//   posedge while the slave is idle; the data phase ends at the first posedge
//   where HREADYOUT=1, and writes commit on that edge with HWDATA[7:0].
//   Ports:
//     Clk, Rst             clock, asynchronous active-low reset
//     HSEL..HREADYIN       AHB-Lite slave inputs
//     HRDATA, HREADYOUT,
//     HRESP                AHB-Lite slave outputs
//     gpio_in              asynchronous external inputs
//     LED                  DATA_OUT contents
//     irq                  |(IRQ_STATUS & IRQ_EN)
module ahb_gpio_slave
    import ahb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned GPIO_W      = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADYIN,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] LED,
    output logic              irq
);

    localparam bit         HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [2:0] WS_LOAD  = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    slv_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // Registered address-phase information for the current data phase
    logic       dp_valid_q, dp_valid_d;
    logic       dp_write_q, dp_write_d;
    logic       dp_lane0_q, dp_lane0_d;
    logic [1:0] dp_reg_q,   dp_reg_d;

    logic [GPIO_W-1:0] data_out_q,   data_out_d;
    logic [GPIO_W-1:0] irq_en_q,     irq_en_d;
    logic [GPIO_W-1:0] irq_status_q, irq_status_d;

    logic [GPIO_W-1:0] gpio_sync;
    logic [GPIO_W-1:0] gpio_rise;

    logic              accept;
    logic              unmapped;
    logic              wr_en;
    logic [GPIO_W-1:0] clr_mask;
    logic [GPIO_W-1:0] rd_val;

    // Size and byte-lane data above bit 7 do not affect this slave
    logic     unused_bits;
    slv_dbg_t dbg_unused;

    assign unused_bits = ^{HSIZE, HTRANS[0], HWDATA};
    // State snapshot for bound checkers
    assign dbg_unused  = '{state: state_q, wait_cnt: cnt_q, dphase_valid: dp_valid_q};

    gpio_sync_edge #(.W(GPIO_W)) u_sync (
        .clk      (Clk),
        .rst_n    (Rst),
        .async_in (gpio_in),
        .sync_out (gpio_sync),
        .rise     (gpio_rise)
    );

    // Only IDLE takes new address phases; every other state either holds
    // HREADYOUT low or is the closing cycle of an ERROR response.
    assign accept   = HSEL & HTRANS[1] & HREADYIN & (state_q == ST_IDLE);
    assign unmapped = (HADDR[31:4] != 28'd0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (unmapped) begin
                        state_d = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state_q)
            ST_IDLE: ;
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // ---------------- Data-phase capture ----------------
    // dp_valid marks a mapped data phase; it survives WAIT and is consumed in
    // IDLE, where a pipelined address phase may load the next one.
    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_lane0_d = dp_lane0_q;
        dp_reg_d   = dp_reg_q;
        if (state_q == ST_IDLE) begin
            dp_valid_d = accept & ~unmapped;
            if (accept) begin
                dp_write_d = HWRITE;
                dp_lane0_d = (HADDR[1:0] == 2'b00);
                dp_reg_d   = HADDR[3:2];
            end
        end else if (state_q != ST_WAIT) begin
            dp_valid_d = 1'b0;
        end
    end

    // Write commits on the edge that ends the data phase (IDLE means HREADYOUT=1)
    assign wr_en    = dp_valid_q & dp_write_q & dp_lane0_q & (state_q == ST_IDLE);
    assign clr_mask = (wr_en && dp_reg_q == REG_IRQ_STATUS) ? HWDATA[GPIO_W-1:0] : '0;

    // ---------------- Register file ----------------
    always_comb begin
        data_out_d = data_out_q;
        irq_en_d   = irq_en_q;
        if (wr_en && dp_reg_q == REG_DATA_OUT) data_out_d = HWDATA[GPIO_W-1:0];
        if (wr_en && dp_reg_q == REG_IRQ_EN)   irq_en_d   = HWDATA[GPIO_W-1:0];
        // Clear applied first so a coincident rising edge wins
        irq_status_d = (irq_status_q & ~clr_mask) | gpio_rise;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            dp_valid_q   <= 1'b0;
            dp_write_q   <= 1'b0;
            dp_lane0_q   <= 1'b0;
            dp_reg_q     <= 2'd0;
            data_out_q   <= '0;
            irq_en_q     <= '0;
            irq_status_q <= '0;
        end else begin
            dp_valid_q   <= dp_valid_d;
            dp_write_q   <= dp_write_d;
            dp_lane0_q   <= dp_lane0_d;
            dp_reg_q     <= dp_reg_d;
            data_out_q   <= data_out_d;
            irq_en_q     <= irq_en_d;
            irq_status_q <= irq_status_d;
        end
    end

    // ---------------- Read data ----------------
    always_comb begin
        rd_val = '0;
        if (dp_valid_q && !dp_write_q) begin
            unique case (dp_reg_q)
                REG_DATA_OUT:   rd_val = data_out_q;
                REG_DATA_IN:    rd_val = gpio_sync;
                REG_IRQ_EN:     rd_val = irq_en_q;
                REG_IRQ_STATUS: rd_val = irq_status_q;
                default:        rd_val = '0;
            endcase
        end
    end

    assign HRDATA = 32'(rd_val);
    assign LED    = data_out_q;
    assign irq    = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_ahb_gpio_slave.sv
// tb_ahb_gpio_slave
//   Two slave instances: u_dut0 with no wait states, u_dut2 with two. They share
//   the bus except HSEL; HREADYIN follows the selected slave. A reference model
//   holds the register contents of each instance as plain arrays.
module tb_ahb_gpio_slave;

    logic        clk;
    logic        rst_n;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [7:0]  gpio_in;
    logic        cur;

    logic [31:0] rdata0, rdata2;
    logic        ready0, ready2, resp0, resp2, irq0, irq2;
    logic [7:0]  led0, led2;

    logic [31:0] b_rdata;
    logic        b_ready, b_resp, b_irq;
    logic [7:0]  b_led;

    assign b_rdata = cur ? rdata2 : rdata0;
    assign b_ready = cur ? ready2 : ready0;
    assign b_resp  = cur ? resp2  : resp0;
    assign b_irq   = cur ? irq2   : irq0;
    assign b_led   = cur ? led2   : led0;

    ahb_gpio_slave #(.WAIT_STATES(0), .GPIO_W(8)) u_dut0 (
        .Clk(clk), .Rst(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADYIN(b_ready),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0),
        .gpio_in(gpio_in), .LED(led0), .irq(irq0)
    );

    ahb_gpio_slave #(.WAIT_STATES(2), .GPIO_W(8)) u_dut2 (
        .Clk(clk), .Rst(rst_n), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADYIN(b_ready),
        .HRDATA(rdata2), .HREADYOUT(ready2), .HRESP(resp2),
        .gpio_in(gpio_in), .LED(led2), .irq(irq2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_out [2];
    logic [7:0] m_en  [2];
    logic [7:0] m_st  [2];
    logic [7:0] m_gpio;

    function automatic logic m_irq(input int d);
        return |(m_st[d] & m_en[d]);
    endfunction

    // Expected data-phase length for a mapped access on instance d
    function automatic int m_waits(input int d, input logic unm);
        if (unm) return 1;
        return (d == 1) ? 2 : 0;
    endfunction

    // Applies a new input value and holds it long enough to pass the synchroniser
    task automatic set_gpio(input logic [7:0] v);
        for (int d = 0; d < 2; d++) m_st[d] = m_st[d] | (v & ~m_gpio);
        m_gpio  = v;
        gpio_in = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Single transfer; entered and left at 1ns after a posedge
    task automatic ahb_xfer(input int d, input logic [31:0] addr, input logic wr,
                            input logic [2:0] size, input logic [31:0] wd,
                            output logic [31:0] rd, output logic rsp,
                            output int waits, output logic wait_rsp);
        logic done;
        cur    = d[0];
        hsel0  = (d == 0);
        hsel2  = (d == 1);
        haddr  = addr;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = size;
        @(posedge clk);
        #1;
        hsel0    = 1'b0;
        hsel2    = 1'b0;
        htrans   = 2'b00;
        hwdata   = wd;
        waits    = 0;
        wait_rsp = 1'b0;
        rd       = '0;
        rsp      = 1'b0;
        done     = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (b_ready) begin
                rd   = b_rdata;
                rsp  = b_resp;
                done = 1'b1;
            end else begin
                waits++;
                wait_rsp = b_resp;
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL xfer_timeout addr=%h got no HREADYOUT, required within 20 cycles", addr);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cur = d[0];
            #0;
            checks++;
            if ({b_led, b_ready, b_resp, b_irq, b_rdata} !== {8'h00, 1'b1, 1'b0, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL reset dut%0d got led=%h rdy=%b resp=%b irq=%b rdata=%h, required 00 1 0 0 0",
                         d, b_led, b_ready, b_resp, b_irq, b_rdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        cur    = 1'b0;
        hsel0  = 1'b1;
        haddr  = 32'h0;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'd0;
        @(posedge clk);
        #1;
        hwrite = 1'b0;
        hwdata = 32'h0000_000A;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_ready got %b, required 1", b_ready);
        end
        @(posedge clk);
        #1;
        hsel0  = 1'b0;
        htrans = 2'b00;
        m_out[0] = 8'h0A;
        checks++;
        if (led0 !== 8'h0A) begin
            errors++;
            $display("FAIL b2b_led got %h, required 0a", led0);
        end
        @(negedge clk);
        checks++;
        if ({b_ready, b_resp, b_rdata} !== {1'b1, 1'b0, 32'h0000_000A}) begin
            errors++;
            $display("FAIL b2b_read got rdy=%b resp=%b rdata=%h, required 1 0 0000000a",
                     b_ready, b_resp, b_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        rsp, wrsp;
        int          w;
        set_gpio(8'h5A);
        ahb_xfer(1, 32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, w, wrsp);
        checks++;
        if (w !== 2 || rd !== 32'h5A || rsp !== 1'b0) begin
            errors++;
            $display("FAIL ws2_read got waits=%0d rdata=%h resp=%b, required 2 0000005a 0", w, rd, rsp);
        end
        ahb_xfer(0, 32'h4, 1'b0, 3'd0, 32'h0, rd, rsp, w, wrsp);
        checks++;
        if (w !== 0 || rd !== 32'h5A || rsp !== 1'b0) begin
            errors++;
            $display("FAIL ws0_read got waits=%0d rdata=%h resp=%b, required 0 0000005a 0", w, rd, rsp);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        logic        rsp, wrsp;
        int          w;
        for (int d = 0; d < 2; d++) begin
            ahb_xfer(d, 32'h20, 1'b1, 3'd0, 32'hFF, rd, rsp, w, wrsp);
            checks++;
            if (w !== 1 || wrsp !== 1'b1 || rsp !== 1'b1) begin
                errors++;
                $display("FAIL unmapped_resp dut%0d got waits=%0d resp1=%b resp2=%b, required 1 1 1",
                         d, w, wrsp, rsp);
            end
            checks++;
            if (b_led !== m_out[d]) begin
                errors++;
                $display("FAIL unmapped_led dut%0d got %h, required %h", d, b_led, m_out[d]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, addr;
        logic        rsp, wrsp, unm, wr;
        logic [1:0]  r, lane;
        logic [2:0]  size;
        logic [7:0]  exp_rd;
        int          w, d;
        for (int n = 0; n < 48; n++) begin
            d    = int'($urandom_range(0, 1));
            unm  = ($urandom_range(0, 7) == 0);
            r    = 2'($urandom_range(0, 3));
            lane = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            wr   = 1'($urandom_range(0, 1));
            size = 3'($urandom_range(0, 2));
            wd   = $urandom;
            addr = {unm ? 28'($urandom_range(1, 1000)) : 28'd0, r, lane};
            case (r)
                2'd0:    exp_rd = m_out[d];
                2'd1:    exp_rd = m_gpio;
                2'd2:    exp_rd = m_en[d];
                default: exp_rd = m_st[d];
            endcase
            ahb_xfer(d, addr, wr, size, wd, rd, rsp, w, wrsp);
            if (!unm && wr && lane == 2'd0) begin
                case (r)
                    2'd0:    m_out[d] = wd[7:0];
                    2'd2:    m_en[d]  = wd[7:0];
                    2'd3:    m_st[d]  = m_st[d] & ~wd[7:0];
                    default: ;
                endcase
            end
            checks++;
            if (w !== m_waits(d, unm) || rsp !== unm) begin
                errors++;
                $display("FAIL rnd_resp n=%0d addr=%h got waits=%0d resp=%b, required %0d %b",
                         n, addr, w, rsp, m_waits(d, unm), unm);
            end
            if (!unm && !wr) begin
                checks++;
                if (rd !== {24'h0, exp_rd}) begin
                    errors++;
                    $display("FAIL rnd_read n=%0d addr=%h dut%0d got %h, required %h",
                             n, addr, d, rd, {24'h0, exp_rd});
                end
            end
            checks++;
            if (led0 !== m_out[0] || led2 !== m_out[1] || irq0 !== m_irq(0) || irq2 !== m_irq(1)) begin
                errors++;
                $display("FAIL rnd_outputs n=%0d got led=%h/%h irq=%b/%b, required %h/%h %b/%b",
                         n, led0, led2, irq0, irq2, m_out[0], m_out[1], m_irq(0), m_irq(1));
            end
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic        rsp, wrsp, seen;
        int          w;
        ahb_xfer(0, 32'h8, 1'b1, 3'd0, 32'h01, rd, rsp, w, wrsp);
        m_en[0] = 8'h01;
        set_gpio(m_gpio & 8'hFE);
        ahb_xfer(0, 32'hC, 1'b1, 3'd0, 32'hFF, rd, rsp, w, wrsp);
        m_st[0] = 8'h00;
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_idle got %b, required 0", irq0);
        end
        // Rising edge on input 0
        m_gpio     = m_gpio | 8'h01;
        gpio_in    = m_gpio;
        m_st[0][0] = 1'b1;
        m_st[1][0] = 1'b1;
        seen       = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = irq0;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise got irq=%b after 3 cycles, required 1", irq0);
        end
        repeat (2) @(posedge clk);
        #1;
        ahb_xfer(0, 32'hC, 1'b1, 3'd0, 32'h01, rd, rsp, w, wrsp);
        m_st[0][0] = 1'b0;
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b, required 0", irq0);
        end
        set_gpio(m_gpio & 8'hFE);
        // Edge raised so its synchronised pulse lands on the clear's commit edge
        m_gpio  = m_gpio | 8'h01;
        gpio_in = m_gpio;
        cur     = 1'b0;
        @(posedge clk);
        #1;
        hsel0  = 1'b1;
        haddr  = 32'hC;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'd0;
        @(posedge clk);
        #1;
        hsel0  = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h01;
        @(posedge clk);
        #1;
        m_st[0][0] = 1'b1;
        m_st[1][0] = 1'b1;
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins got %b, required 1", irq0);
        end
        ahb_xfer(0, 32'hC, 1'b0, 3'd0, 32'h0, rd, rsp, w, wrsp);
        checks++;
        if (rd !== {24'h0, m_st[0]}) begin
            errors++;
            $display("FAIL irq_status_read got %h, required %h", rd, {24'h0, m_st[0]});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        rsp, wrsp;
        int          w;
        ahb_xfer(1, 32'h0, 1'b1, 3'd0, 32'h77, rd, rsp, w, wrsp);
        m_out[1] = 8'h77;
        checks++;
        if (led2 !== 8'h77) begin
            errors++;
            $display("FAIL rstmid_setup_led got %h, required 77", led2);
        end
        cur    = 1'b1;
        hsel2  = 1'b1;
        haddr  = 32'h0;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'd0;
        @(posedge clk);
        #1;
        hsel2  = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h33;
        @(negedge clk);
        checks++;
        if (ready2 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_in_wait got ready=%b, required 0", ready2);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led2, ready2, resp2, irq2, rdata2, led0, irq0} !== {8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async got led=%h rdy=%b resp=%b irq=%b rdata=%h led0=%h irq0=%b, required 00 1 0 0 0 00 0",
                     led2, ready2, resp2, irq2, rdata2, led0, irq0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_out[d] = 8'h00;
            m_en[d]  = 8'h00;
            // Synchroniser restarts from 0, so every high input reads as a new edge
            m_st[d]  = m_gpio;
        end
        repeat (4) @(posedge clk);
        #1;
        ahb_xfer(1, 32'h0, 1'b0, 3'd0, 32'h0, rd, rsp, w, wrsp);
        checks++;
        if (rd !== 32'h0 || w !== 2 || led2 !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_read got rdata=%h waits=%0d led=%h, required 0 2 00", rd, w, led2);
        end
        ahb_xfer(1, 32'hC, 1'b0, 3'd0, 32'h0, rd, rsp, w, wrsp);
        checks++;
        if (rd !== {24'h0, m_st[1]}) begin
            errors++;
            $display("FAIL rstmid_status got %h, required %h", rd, {24'h0, m_st[1]});
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        hsel0   = 1'b0;
        hsel2   = 1'b0;
        haddr   = '0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        hsize   = 3'd0;
        hwdata  = '0;
        gpio_in = 8'h00;
        cur     = 1'b0;
        m_gpio  = 8'h00;
        for (int d = 0; d < 2; d++) begin
            m_out[d] = 8'h00;
            m_en[d]  = 8'h00;
            m_st[d]  = 8'h00;
        end
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_unmapped();
        test_random();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
